// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel-source path: panel geometry, pattern ids,
// RGB888 colours, debug view and the per-axis bounce helper.
package lcd_pkg;

  localparam logic [10:0] LCD_H_DISP = 11'd800;
  localparam logic [10:0] LCD_V_DISP = 11'd480;

  typedef logic [2:0] pattern_id_t;
  localparam pattern_id_t PAT_COLORBAR = 3'd0;
  localparam pattern_id_t PAT_GRAY     = 3'd1;
  localparam pattern_id_t PAT_CHECKER  = 3'd2;
  localparam pattern_id_t PAT_GRID     = 3'd3;
  localparam pattern_id_t PAT_BOX      = 3'd4;
  localparam int          PAT_NUM      = 5;

  typedef logic [23:0] rgb_t;
  localparam rgb_t WHITE   = 24'hFFFFFF;
  localparam rgb_t BLACK   = 24'h000000;
  localparam rgb_t RED     = 24'hFF0000;
  localparam rgb_t GREEN   = 24'h00FF00;
  localparam rgb_t BLUE    = 24'h0000FF;
  localparam rgb_t YELLOW  = 24'hFFFF00;
  localparam rgb_t CYAN    = 24'h00FFFF;
  localparam rgb_t MAGENTA = 24'hFF00FF;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    logic [10:0] pos;
    dir_e        dir;
  } axis_t;

  typedef struct packed {
    logic [10:0] box_x;
    logic [10:0] box_y;
    dir_e        dir_x;
    dir_e        dir_y;
    logic [15:0] frame_cnt;
    logic        next_pending;
  } lcd_dbg_t;

  // Ids past the last pattern fold back to the colour bar, so a corrupted id self-heals.
  function automatic pattern_id_t next_pattern(input pattern_id_t id);
    pattern_id_t nxt;
    if (id >= PAT_BOX) nxt = PAT_COLORBAR;
    else               nxt = id + 3'd1;
    return nxt;
  endfunction

  // One frame of motion on one axis; 12-bit arithmetic keeps pos+step from wrapping.
  function automatic axis_t bounce_axis(input axis_t cur, input logic [11:0] lim,
                                        input logic [11:0] step);
    axis_t       nxt;
    logic [11:0] pos12;
    logic [11:0] sum;
    logic [11:0] diff;
    nxt   = cur;
    pos12 = {1'b0, cur.pos};
    sum   = pos12 + step;
    diff  = pos12 - step;
    if (cur.dir == DIR_POS) begin
      if (sum >= lim) begin
        nxt.pos = lim[10:0];
        nxt.dir = DIR_NEG;
      end else begin
        nxt.pos = sum[10:0];
      end
    end else begin
      if (pos12 <= step) begin
        nxt.pos = 11'd0;
        nxt.dir = DIR_POS;
      end else begin
        nxt.pos = diff[10:0];
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Request/response bundle between lcd_driver (master) and the pattern source (slave).
interface lcd_pattern_gen_if;
  import lcd_pkg::*;

  // Request/response: coordinates are valid only in a cycle with i_data_req high;
  // o_pixel_data answers that request exactly one pclk later and is zero otherwise.
  // There is no backpressure: the source always accepts a request.
  logic [10:0] i_pixel_xpos;
  logic [10:0] i_pixel_ypos;
  logic        i_data_req;
  logic        i_auto_en;
  logic        i_next;
  logic [23:0] o_pixel_data;
  logic [2:0]  o_pattern_id;
  lcd_dbg_t    o_dbg;

  modport master (
    output i_pixel_xpos, i_pixel_ypos, i_data_req, i_auto_en, i_next,
    input  o_pixel_data, o_pattern_id, o_dbg
  );

  modport slave (
    input  i_pixel_xpos, i_pixel_ypos, i_data_req, i_auto_en, i_next,
    output o_pixel_data, o_pattern_id, o_dbg
  );

endinterface

// File: rtl/lcd_box_bounce.sv
// Bouncing-box position and direction; advances one step per strobe on each axis.
module lcd_box_bounce
  import lcd_pkg::*;
#(
  parameter logic [10:0] P_H_DISP   = LCD_H_DISP,
  parameter logic [10:0] P_V_DISP   = LCD_V_DISP,
  parameter logic [10:0] P_BOX_SIZE = 11'd64,
  parameter logic [10:0] P_BOX_STEP = 11'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_step,
  output logic [10:0] o_box_x,
  output logic [10:0] o_box_y,
  output dir_e        o_dir_x,
  output dir_e        o_dir_y
);

  localparam logic [11:0] X_MAX = {1'b0, P_H_DISP} - {1'b0, P_BOX_SIZE};
  localparam logic [11:0] Y_MAX = {1'b0, P_V_DISP} - {1'b0, P_BOX_SIZE};
  localparam logic [11:0] STEP  = {1'b0, P_BOX_STEP};

  axis_t x_q, x_d;
  axis_t y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (i_step) begin
      x_d = bounce_axis(x_q, X_MAX, STEP);
      y_d = bounce_axis(y_q, Y_MAX, STEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '{pos: 11'd0, dir: DIR_POS};
      y_q <= '{pos: 11'd0, dir: DIR_POS};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign o_box_x = x_q.pos;
  assign o_box_y = y_q.pos;
  assign o_dir_x = x_q.dir;
  assign o_dir_y = y_q.dir;

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern pixel source for lcd_driver: five patterns, frame-synchronous
// pattern stepping and box motion, one-pclk registered pixel latency.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter logic [10:0] P_H_DISP      = LCD_H_DISP,
  parameter logic [10:0] P_V_DISP      = LCD_V_DISP,
  parameter int          P_TILE_LOG2   = 5,
  parameter logic [10:0] P_BOX_SIZE    = 11'd64,
  parameter logic [10:0] P_BOX_STEP    = 11'd4,
  parameter logic [15:0] P_AUTO_FRAMES = 16'd120
) (
  input logic          i_lcd_pclk,
  input logic          i_rst,
  lcd_pattern_gen_if.slave bus
);

  // Bar edges are elaboration-time constants so the bar lookup is pure compares.
  localparam logic [10:0] BAR_W = P_H_DISP / 11'd8;
  localparam logic [10:0] BAR1  = BAR_W;
  localparam logic [10:0] BAR2  = BAR_W * 11'd2;
  localparam logic [10:0] BAR3  = BAR_W * 11'd3;
  localparam logic [10:0] BAR4  = BAR_W * 11'd4;
  localparam logic [10:0] BAR5  = BAR_W * 11'd5;
  localparam logic [10:0] BAR6  = BAR_W * 11'd6;
  localparam logic [10:0] BAR7  = BAR_W * 11'd7;

  rgb_t        pixel_q, pixel_d;
  pattern_id_t pattern_id_q, pattern_id_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        next_pending_q, next_pending_d;

  logic        frame_end;
  logic        auto_roll;
  logic        advance;
  logic        box_step;
  logic [10:0] box_x, box_y;
  dir_e        dir_x, dir_y;

  logic [10:0] x, y;
  logic [8:0]  gray_idx;
  logic [7:0]  gray;
  logic [11:0] x12, y12, bx12, by12;
  logic        in_box;
  rgb_t        bar_rgb;
  rgb_t        pat_rgb;

  assign x = bus.i_pixel_xpos;
  assign y = bus.i_pixel_ypos;

  assign frame_end = bus.i_data_req && (x == P_H_DISP - 11'd1) && (y == P_V_DISP - 11'd1);
  assign box_step  = frame_end && (pattern_id_q == PAT_BOX);

  lcd_box_bounce #(
    .P_H_DISP   (P_H_DISP),
    .P_V_DISP   (P_V_DISP),
    .P_BOX_SIZE (P_BOX_SIZE),
    .P_BOX_STEP (P_BOX_STEP)
  ) u_box (
    .clk     (i_lcd_pclk),
    .rst     (i_rst),
    .i_step  (box_step),
    .o_box_x (box_x),
    .o_box_y (box_y),
    .o_dir_x (dir_x),
    .o_dir_y (dir_y)
  );

  always_comb begin
    bar_rgb = BLACK;
    if      (x < BAR1) bar_rgb = WHITE;
    else if (x < BAR2) bar_rgb = YELLOW;
    else if (x < BAR3) bar_rgb = CYAN;
    else if (x < BAR4) bar_rgb = GREEN;
    else if (x < BAR5) bar_rgb = MAGENTA;
    else if (x < BAR6) bar_rgb = RED;
    else if (x < BAR7) bar_rgb = BLUE;
    else               bar_rgb = BLACK;

    gray_idx = x[10:2];
    gray     = (gray_idx > 9'd255) ? 8'hFF : gray_idx[7:0];

    x12    = {1'b0, x};
    y12    = {1'b0, y};
    bx12   = {1'b0, box_x};
    by12   = {1'b0, box_y};
    in_box = (x12 >= bx12) && (x12 < bx12 + {1'b0, P_BOX_SIZE}) &&
             (y12 >= by12) && (y12 < by12 + {1'b0, P_BOX_SIZE});

    case (pattern_id_q)
      PAT_GRAY:    pat_rgb = {gray, gray, gray};
      PAT_CHECKER: pat_rgb = (x[P_TILE_LOG2] ^ y[P_TILE_LOG2]) ? WHITE : BLACK;
      PAT_GRID:    pat_rgb = ((x[P_TILE_LOG2-1:0] == '0) || (y[P_TILE_LOG2-1:0] == '0) ||
                              (x == P_H_DISP - 11'd1) || (y == P_V_DISP - 11'd1)) ? WHITE : BLACK;
      PAT_BOX:     pat_rgb = in_box ? RED : BLUE;
      default:     pat_rgb = bar_rgb;
    endcase
  end

  // Control state only moves at frame_end, so the last pixel of a frame still uses the old state.
  always_comb begin
    pixel_d        = bus.i_data_req ? pat_rgb : BLACK;
    auto_roll      = bus.i_auto_en && frame_end && (frame_cnt_q == P_AUTO_FRAMES - 16'd1);
    advance        = frame_end && (auto_roll || next_pending_q || bus.i_next);
    next_pending_d = next_pending_q | bus.i_next;
    frame_cnt_d    = frame_cnt_q;
    pattern_id_d   = pattern_id_q;

    if (!bus.i_auto_en)  frame_cnt_d = 16'd0;
    else if (auto_roll)  frame_cnt_d = 16'd0;
    else if (frame_end)  frame_cnt_d = frame_cnt_q + 16'd1;

    if (frame_end) next_pending_d = 1'b0;
    if (advance)   pattern_id_d   = next_pattern(pattern_id_q);
  end

  always_ff @(posedge i_lcd_pclk or posedge i_rst) begin
    if (i_rst) begin
      pixel_q        <= BLACK;
      pattern_id_q   <= PAT_COLORBAR;
      frame_cnt_q    <= 16'd0;
      next_pending_q <= 1'b0;
    end else begin
      pixel_q        <= pixel_d;
      pattern_id_q   <= pattern_id_d;
      frame_cnt_q    <= frame_cnt_d;
      next_pending_q <= next_pending_d;
    end
  end

  assign bus.o_pixel_data = pixel_q;
  assign bus.o_pattern_id = pattern_id_q;
  assign bus.o_dbg        = '{box_x:        box_x,
                              box_y:        box_y,
                              dir_x:        dir_x,
                              dir_y:        dir_y,
                              frame_cnt:    frame_cnt_q,
                              next_pending: next_pending_q};

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen: pattern pixels, frame-synchronous stepping,
// box bounce and asynchronous reset, with hand-computed expectations.
module tb_lcd_pattern_gen;
  import lcd_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  lcd_pattern_gen_if bus ();

  lcd_pattern_gen #(
    .P_AUTO_FRAMES (16'd2)
  ) dut (
    .i_lcd_pclk (clk),
    .i_rst      (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: apply inputs for one cycle, return at the next negedge.
  task automatic step(input logic [10:0] x, input logic [10:0] y, input logic req,
                      input logic nxt);
    bus.i_pixel_xpos = x;
    bus.i_pixel_ypos = y;
    bus.i_data_req   = req;
    bus.i_next       = nxt;
    @(negedge clk);
  endtask

  task automatic pix(input logic [10:0] x, input logic [10:0] y);
    step(x, y, 1'b1, 1'b0);
  endtask

  task automatic frame_end(input logic nxt);
    step(11'd799, 11'd479, 1'b1, nxt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_data_req = 1'b0;
    bus.i_next     = 1'b0;
    bus.i_auto_en  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int exp_ids[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4};

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    bus.i_pixel_xpos = '0;
    bus.i_pixel_ypos = '0;
    bus.i_data_req   = 1'b0;
    bus.i_auto_en    = 1'b0;
    bus.i_next       = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_pixel", 32'(bus.o_pixel_data), 32'h000000);
    chk("rst_id", 32'(bus.o_pattern_id), 32'd0);
    chk("rst_box_x", 32'(bus.o_dbg.box_x), 32'd0);
    chk("rst_box_y", 32'(bus.o_dbg.box_y), 32'd0);
    chk("rst_dir_x", 32'(bus.o_dbg.dir_x), 32'(DIR_POS));
    chk("rst_cnt", 32'(bus.o_dbg.frame_cnt), 32'd0);
    chk("rst_pend", 32'(bus.o_dbg.next_pending), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Colour bar
    pix(11'd0, 11'd0);     chk("bar_x0", 32'(bus.o_pixel_data), 32'hFFFFFF);
    chk("bar_id", 32'(bus.o_pattern_id), 32'd0);
    step(11'd0, 11'd0, 1'b0, 1'b0); chk("noreq", 32'(bus.o_pixel_data), 32'h000000);
    pix(11'd99, 11'd7);    chk("bar_x99", 32'(bus.o_pixel_data), 32'hFFFFFF);
    pix(11'd100, 11'd7);   chk("bar_x100", 32'(bus.o_pixel_data), 32'hFFFF00);
    pix(11'd250, 11'd7);   chk("bar_x250", 32'(bus.o_pixel_data), 32'h00FFFF);
    pix(11'd399, 11'd7);   chk("bar_x399", 32'(bus.o_pixel_data), 32'h00FF00);
    pix(11'd400, 11'd7);   chk("bar_x400", 32'(bus.o_pixel_data), 32'hFF00FF);
    pix(11'd550, 11'd7);   chk("bar_x550", 32'(bus.o_pixel_data), 32'hFF0000);
    pix(11'd699, 11'd7);   chk("bar_x699", 32'(bus.o_pixel_data), 32'h0000FF);
    pix(11'd799, 11'd7);   chk("bar_x799", 32'(bus.o_pixel_data), 32'h000000);

    // Auto cycling, two frames per pattern
    bus.i_auto_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("auto_id_f%0d", k), 32'(bus.o_pattern_id), 32'(exp_ids[k]));
      pix(11'd5, 11'd5);
      chk($sformatf("auto_mid_f%0d", k), 32'(bus.o_pattern_id), 32'(exp_ids[k]));
      frame_end(1'b0);
    end
    chk("auto_wrap", 32'(bus.o_pattern_id), 32'd0);

    // Manual stepping
    do_reset();
    step(11'd10, 11'd10, 1'b1, 1'b1);
    chk("man_hold_id", 32'(bus.o_pattern_id), 32'd0);
    chk("man_pend", 32'(bus.o_dbg.next_pending), 32'd1);
    pix(11'd20, 11'd10);
    chk("man_hold_id2", 32'(bus.o_pattern_id), 32'd0);
    frame_end(1'b0);
    chk("man_step_id", 32'(bus.o_pattern_id), 32'd1);
    chk("man_pend_clr", 32'(bus.o_dbg.next_pending), 32'd0);

    // Gray ramp
    pix(11'd4, 11'd0);     chk("gray_x4", 32'(bus.o_pixel_data), 32'h010101);
    pix(11'd400, 11'd9);   chk("gray_x400", 32'(bus.o_pixel_data), 32'h646464);
    pix(11'd799, 11'd9);   chk("gray_x799", 32'(bus.o_pixel_data), 32'hC7C7C7);

    frame_end(1'b1);
    chk("next_at_fe", 32'(bus.o_pattern_id), 32'd2);

    // Checkerboard
    pix(11'd31, 11'd0);    chk("chk_31_0", 32'(bus.o_pixel_data), 32'h000000);
    pix(11'd32, 11'd0);    chk("chk_32_0", 32'(bus.o_pixel_data), 32'hFFFFFF);
    pix(11'd32, 11'd32);   chk("chk_32_32", 32'(bus.o_pixel_data), 32'h000000);
    pix(11'd0, 11'd32);    chk("chk_0_32", 32'(bus.o_pixel_data), 32'hFFFFFF);

    // Auto rollover coinciding with i_next advances once
    bus.i_auto_en = 1'b1;
    frame_end(1'b0);
    chk("sim_cnt1", 32'(bus.o_dbg.frame_cnt), 32'd1);
    chk("sim_id_hold", 32'(bus.o_pattern_id), 32'd2);
    frame_end(1'b1);
    chk("sim_id_once", 32'(bus.o_pattern_id), 32'd3);
    chk("sim_cnt0", 32'(bus.o_dbg.frame_cnt), 32'd0);
    chk("sim_pend0", 32'(bus.o_dbg.next_pending), 32'd0);
    bus.i_auto_en = 1'b0;

    // Grid
    pix(11'd32, 11'd5);    chk("grid_32_5", 32'(bus.o_pixel_data), 32'hFFFFFF);
    pix(11'd33, 11'd5);    chk("grid_33_5", 32'(bus.o_pixel_data), 32'h000000);
    pix(11'd33, 11'd64);   chk("grid_33_64", 32'(bus.o_pixel_data), 32'hFFFFFF);
    pix(11'd799, 11'd5);   chk("grid_799_5", 32'(bus.o_pixel_data), 32'hFFFFFF);
    pix(11'd33, 11'd479);  chk("grid_33_479", 32'(bus.o_pixel_data), 32'hFFFFFF);

    // Bouncing box
    do_reset();
    for (int k = 0; k < 4; k++) frame_end(1'b1);
    chk("box_id", 32'(bus.o_pattern_id), 32'd4);
    chk("box_x_start", 32'(bus.o_dbg.box_x), 32'd0);
    pix(11'd0, 11'd0);     chk("box_0_0", 32'(bus.o_pixel_data), 32'hFF0000);
    pix(11'd63, 11'd63);   chk("box_63_63", 32'(bus.o_pixel_data), 32'hFF0000);
    pix(11'd64, 11'd0);    chk("box_64_0", 32'(bus.o_pixel_data), 32'h0000FF);
    pix(11'd0, 11'd64);    chk("box_0_64", 32'(bus.o_pixel_data), 32'h0000FF);
    frame_end(1'b0);
    chk("box_x_f1", 32'(bus.o_dbg.box_x), 32'd4);
    chk("box_y_f1", 32'(bus.o_dbg.box_y), 32'd4);
    for (int k = 1; k < 184; k++) frame_end(1'b0);
    chk("box_x_f184", 32'(bus.o_dbg.box_x), 32'd736);
    chk("box_dx_f184", 32'(bus.o_dbg.dir_x), 32'(DIR_NEG));
    chk("box_y_f184", 32'(bus.o_dbg.box_y), 32'd96);
    chk("box_dy_f184", 32'(bus.o_dbg.dir_y), 32'(DIR_NEG));
    pix(11'd736, 11'd96);  chk("box_736_96", 32'(bus.o_pixel_data), 32'hFF0000);
    pix(11'd735, 11'd96);  chk("box_735_96", 32'(bus.o_pixel_data), 32'h0000FF);
    pix(11'd799, 11'd159); chk("box_799_159", 32'(bus.o_pixel_data), 32'hFF0000);
    pix(11'd736, 11'd160); chk("box_736_160", 32'(bus.o_pixel_data), 32'h0000FF);
    frame_end(1'b0);
    chk("box_x_f185", 32'(bus.o_dbg.box_x), 32'd732);
    chk("box_y_f185", 32'(bus.o_dbg.box_y), 32'd92);
    pix(11'd732, 11'd92);  chk("box_732_92", 32'(bus.o_pixel_data), 32'hFF0000);
    pix(11'd100, 11'd100); chk("box_bg", 32'(bus.o_pixel_data), 32'h0000FF);

    // Asynchronous reset mid-frame
    bus.i_pixel_xpos = 11'd5;
    bus.i_pixel_ypos = 11'd5;
    bus.i_data_req   = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_pixel", 32'(bus.o_pixel_data), 32'h000000);
    chk("arst_id", 32'(bus.o_pattern_id), 32'd0);
    chk("arst_box_x", 32'(bus.o_dbg.box_x), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pix(11'd0, 11'd0);     chk("arst_resume", 32'(bus.o_pixel_data), 32'hFFFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
